spi_flash_reader: RTL and testbench
===================================

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 HALF_PERIOD, 1, clk cycles per spi_clk half-period; legal range 1..255.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 rstrb  in  1  read strobe; one-cycle pulse requests one 32-bit word.
REQ-005 word_addr  in  22  word address; byte address is {word_addr, 2'b00}.
REQ-006 rdata  out  32  read word, little-endian: first flash byte in [7:0].
REQ-007 rbusy  out  1  high while a read is in progress.
REQ-008 spi_cs_n  out  1  flash chip select, active-low.
REQ-009 spi_clk  out  1  SPI clock, mode 0, idle low.
REQ-010 spi_mosi  out  1  command/address to flash, MSB first.
REQ-011 spi_miso  in  1  data from flash, sampled on spi_clk rising edge.

Function
REQ-012 States SHALL be IDLE, CS_SETUP, SHIFT, CS_HOLD; IDLE->CS_SETUP on rstrb, CS_SETUP->SHIFT after 1 cycle, SHIFT->CS_HOLD after last bit, CS_HOLD->IDLE after 1 cycle.
REQ-013 In IDLE, rstrb SHALL capture word_addr; a later change to word_addr SHALL NOT affect the transaction.
REQ-014 rstrb while not IDLE SHALL be ignored, without queuing.
REQ-015 rbusy SHALL be high from the cycle after the accepted rstrb through the CS_HOLD cycle, and low in IDLE.
REQ-016 Frame SHALL be an 8-bit opcode, a 24-bit byte address, and 32 data bits, giving NBITS=64.
REQ-017 spi_cs_n SHALL be low in CS_SETUP, SHIFT and CS_HOLD, and high in IDLE.
REQ-018 In SHIFT, spi_clk SHALL toggle every HALF_PERIOD cycles, starting low, for exactly NBITS rising edges, and SHALL end low.
REQ-019 spi_mosi SHALL change only while spi_clk is low; bit 0 SHALL be valid from CS_SETUP onward; spi_mosi SHALL be 0 during data bits and in IDLE.
REQ-020 spi_miso SHALL be sampled in the cycle spi_clk rises; data bytes SHALL be received MSB first, with byte k placed in rdata[8k+7:8k].
REQ-021 rbusy SHALL stay high for exactly 2 + 2*HALF_PERIOD*NBITS cycles (130 for HALF_PERIOD=1).
REQ-022 rdata SHALL update only on the CS_HOLD->IDLE transition and SHALL hold until the next completed read.
REQ-023 A byte address above 0xFFFFFC SHALL NOT wrap in the block; the flash handles any wrap.
REQ-024 rstrb in the cycle rbusy falls SHALL start a new read, giving at least 1 cycle of spi_cs_n high between frames.

Reset
REQ-025 On reset: state=IDLE, rbusy=0, spi_cs_n=1, spi_clk=0, spi_mosi=0, rdata=0.
REQ-026 Reset mid-transaction SHALL abort the transaction: in the next cycle spi_cs_n=1, spi_clk=0 and rbusy=0; no partial rdata update; reset overrides a simultaneous rstrb.

Configuration
REQ-027 With SPI_FLASH_FAST_READ_EN defined: opcode 0x0B, 8 dummy bits (mosi=0, miso ignored) after the address, NBITS=72.
REQ-028 Without SPI_FLASH_FAST_READ_EN: opcode 0x03, no dummy bits, NBITS=64.

Structure
REQ-029 Package spi_flash_pkg SHALL hold: opcode constants, the state encoding, and the bit-count constants (opcode 8, address 24, dummy 8, data 32).
REQ-030 Sub-module spi_sclk_div SHALL generate the HALF_PERIOD tick and spi_clk rise/fall strobes; the top level holds the FSM, the bit counter and the shift registers.

Verification
REQ-031 Flash model returns bytes 0x11,0x22,0x33,0x44 at byte address 0x000010; rstrb with word_addr=4 -> mosi frame 0x03 000010, rdata=0x44332211, rbusy high 130 cycles.
REQ-032 HALF_PERIOD=3, word_addr=0x3FFFFF -> address bits 0xFFFFFC, 64 spi_clk periods of 6 cycles each, rbusy high 386 cycles.
REQ-033 rstrb pulsed again at cycle 50 of a read, with a different address -> ignored; only one frame on the bus; rdata from the first address.
REQ-034 reset asserted at cycle 70 of a read -> next cycle spi_cs_n=1, spi_clk=0, rbusy=0, rdata unchanged from its prior value.
REQ-035 With SPI_FLASH_FAST_READ_EN defined, read word_addr=0 with model data 0xDEADBEEF -> opcode 0x0B, 8 dummy clocks, rdata=0xDEADBEEF, rbusy high 146 cycles.
REQ-036 Back-to-back reads with rstrb in the cycle rbusy falls -> spi_cs_n high exactly 1 cycle between frames; both rdata values correct.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared constants, state encoding and helpers for the SPI flash word reader.
// SPI_FLASH_FAST_READ_EN selects FAST_READ (0x0B + 8 dummy bits) instead of READ (0x03).
package spi_flash_pkg;

  localparam logic [7:0] OPC_READ      = 8'h03;
  localparam logic [7:0] OPC_FAST_READ = 8'h0B;

  localparam int OP_BITS    = 8;
  localparam int ADDR_BITS  = 24;
  localparam int DUMMY_BITS = 8;
  localparam int DATA_BITS  = 32;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam bit FAST_READ = 1'b1;
`else
  localparam bit FAST_READ = 1'b0;
`endif

  localparam logic [7:0] OPCODE = FAST_READ ? OPC_FAST_READ : OPC_READ;
  localparam int NDUMMY = FAST_READ ? DUMMY_BITS : 0;
  localparam int NBITS  = OP_BITS + ADDR_BITS + NDUMMY + DATA_BITS;

  typedef enum logic [1:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD
  } state_t;

  // Flash bytes arrive first-byte-in-MSB; the bus word is little-endian.
  function automatic logic [31:0] byte_swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// SPI clock generator: toggles o_sclk every HALF_PERIOD cycles while i_en is high,
// and flags the cycle before each rising/falling edge. Held low and reset when disabled.
module spi_sclk_div #(
  parameter int HALF_PERIOD = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [7:0] HP_LAST = 8'(HALF_PERIOD - 1);

  logic [7:0] r_cnt;
  logic       r_sclk;
  logic       w_tick;

  assign w_tick = i_en && (r_cnt == HP_LAST);

  always_ff @(posedge clk) begin
    if (reset || !i_en) begin
      r_cnt  <= 8'd0;
      r_sclk <= 1'b0;
    end else if (w_tick) begin
      r_cnt  <= 8'd0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_sclk = r_sclk;
  assign o_rise = w_tick & ~r_sclk;
  assign o_fall = w_tick &  r_sclk;

endmodule

// File: rtl/spi_flash_reader.sv
// Single-word SPI flash reader (mode 0): one rstrb fetches 32 bits, rbusy for 2+2*HALF_PERIOD*NBITS cycles.
// SPI_FLASH_FAST_READ_EN switches to FAST_READ with 8 dummy bits; strobes while busy are dropped.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int HALF_PERIOD = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rstrb,
  input  logic [21:0] word_addr,
  output logic [31:0] rdata,
  output logic        rbusy,
  output logic        spi_cs_n,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [6:0] LAST_BIT   = 7'(NBITS - 1);
  localparam logic [6:0] DATA_START = 7'(NBITS - DATA_BITS);

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic [NBITS-1:0]   r_tx;
  logic [31:0]        r_rx;
  logic [31:0]        r_rdata;
  logic [6:0]         r_bit_cnt;
  logic               w_sclk;
  logic               w_rise;
  logic               w_fall;
  logic               w_shift_en;

  assign w_shift_en = (r_state == SHIFT);

  spi_sclk_div #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_sclk_div (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_shift_en),
    .o_sclk (w_sclk),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (rstrb) begin
          w_accept = 1'b1;
          w_next   = CS_SETUP;
        end
      end
      CS_SETUP: w_next = SHIFT;
      SHIFT:    if (w_fall && (r_bit_cnt == LAST_BIT)) w_next = CS_HOLD;
      CS_HOLD:  w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // The frame is loaded whole at accept so the opcode MSB is on mosi from CS_SETUP;
  // zeros shifted in keep mosi low through dummy/data bits and afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx      <= '0;
      r_rx      <= 32'd0;
      r_rdata   <= 32'd0;
      r_bit_cnt <= 7'd0;
    end else begin
      if (w_accept) begin
        r_tx      <= {OPCODE, word_addr, 2'b00, {(NBITS - OP_BITS - ADDR_BITS){1'b0}}};
        r_bit_cnt <= 7'd0;
      end
      if (w_shift_en && w_rise && (r_bit_cnt >= DATA_START)) begin
        r_rx <= {r_rx[30:0], spi_miso};
      end
      if (w_shift_en && w_fall) begin
        r_tx      <= {r_tx[NBITS-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 7'd1;
      end
      if (r_state == CS_HOLD) begin
        r_rdata <= byte_swap32(r_rx);
      end
    end
  end

  assign spi_cs_n = (r_state == IDLE);
  assign rbusy    = (r_state != IDLE);
  assign spi_clk  = w_sclk;
  assign spi_mosi = r_tx[NBITS-1];
  assign rdata    = r_rdata;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader: HALF_PERIOD=1 and HALF_PERIOD=3 instances share one flash model.
module tb_spi_flash_reader;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] EXP_OP = 8'h0B;
  localparam int EXP_NB = 72;
  localparam int BUSY1  = 146;
  localparam int BUSY3  = 434;
`else
  localparam logic [7:0] EXP_OP = 8'h03;
  localparam int EXP_NB = 64;
  localparam int BUSY1  = 130;
  localparam int BUSY3  = 386;
`endif
  localparam int DSTART = EXP_NB - 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        rstrb;
  logic        sel;
  logic [21:0] word_addr;
  logic        miso = 1'b0;

  logic        rstrb1, rstrb3;
  logic [31:0] rdata1, rdata3;
  logic        busy1, busy3, cs1, cs3, sclk1, sclk3, mosi1, mosi3;
  logic        m_cs_n, m_sclk, m_mosi, m_busy;
  logic [31:0] m_rdata;

  assign rstrb1  = rstrb & ~sel;
  assign rstrb3  = rstrb &  sel;
  assign m_cs_n  = sel ? cs3    : cs1;
  assign m_sclk  = sel ? sclk3  : sclk1;
  assign m_mosi  = sel ? mosi3  : mosi1;
  assign m_busy  = sel ? busy3  : busy1;
  assign m_rdata = sel ? rdata3 : rdata1;

  always #5 clk = ~clk;

  spi_flash_reader #(.HALF_PERIOD(1)) dut1 (
    .clk(clk), .reset(reset), .rstrb(rstrb1), .word_addr(word_addr),
    .rdata(rdata1), .rbusy(busy1), .spi_cs_n(cs1), .spi_clk(sclk1),
    .spi_mosi(mosi1), .spi_miso(miso)
  );

  spi_flash_reader #(.HALF_PERIOD(3)) dut3 (
    .clk(clk), .reset(reset), .rstrb(rstrb3), .word_addr(word_addr),
    .rdata(rdata3), .rbusy(busy3), .spi_cs_n(cs3), .spi_clk(sclk3),
    .spi_mosi(mosi3), .spi_miso(miso)
  );

  function automatic logic [7:0] fbyte(input logic [23:0] a);
    case (a)
      24'h000000: return 8'hEF;
      24'h000001: return 8'hBE;
      24'h000002: return 8'hAD;
      24'h000003: return 8'hDE;
      24'h000010: return 8'h11;
      24'h000011: return 8'h22;
      24'h000012: return 8'h33;
      24'h000013: return 8'h44;
      default:    return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // Flash model and bus monitor: counts frames/rises, captures opcode+address,
  // drives data on falling spi_clk after the address (and dummy) bits.
  int          cyc = 0;
  int          frames = 0;
  int          rise_cnt = 0;
  int          mosi_nz = 0;
  int          first_rise = 0;
  int          last_rise = 0;
  logic [31:0] cmd_cap = 32'd0;
  logic        p_cs = 1'b1;
  logic        p_sclk = 1'b0;

  always @(negedge clk) cyc++;

  always @(m_cs_n, m_sclk) begin : flash_model
    int k;
    logic [7:0] b;
    if (p_cs && !m_cs_n) begin
      frames++;
      rise_cnt = 0;
      cmd_cap  = 32'd0;
      mosi_nz  = 0;
    end
    if (!p_sclk && m_sclk && !m_cs_n) begin
      if (rise_cnt < 32) cmd_cap = {cmd_cap[30:0], m_mosi};
      else if (m_mosi)   mosi_nz++;
      rise_cnt++;
      if (rise_cnt == 1) first_rise = cyc;
      last_rise = cyc;
    end
    if (p_sclk && !m_sclk && !m_cs_n) begin
      k = rise_cnt - DSTART;
      if (k >= 0 && k < 32) begin
        b    = fbyte(cmd_cap[23:0] + 24'(k / 8));
        miso = b[7 - (k % 8)];
      end
    end
    p_cs   = m_cs_n;
    p_sclk = m_sclk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic start_read(input logic [21:0] a);
    @(negedge clk);
    rstrb     = 1'b1;
    word_addr = a;
    @(negedge clk);
    rstrb     = 1'b0;
    word_addr = ~a;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (m_busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic        sel;
    logic [21:0] addr;
    logic [31:0] cmd;
    logic [31:0] rdata;
    int          busy;
  } vec_t;

  vec_t vec[4];

  initial begin
    int n;
    int f0;
    vec[0] = '{1'b0, 22'h000004, {EXP_OP, 24'h000010}, 32'h44332211, BUSY1};
    vec[1] = '{1'b0, 22'h000000, {EXP_OP, 24'h000000}, 32'hDEADBEEF, BUSY1};
    vec[2] = '{1'b1, 22'h3FFFFF, {EXP_OP, 24'hFFFFFC}, 32'hA5A4A7A6, BUSY3};
    vec[3] = '{1'b0, 22'h123456, {EXP_OP, 24'h48D158}, 32'h01000302, BUSY1};

    reset = 1'b1; rstrb = 1'b0; sel = 1'b0; word_addr = 22'd0;
    repeat (3) @(negedge clk);
    chk("rst_cs1",    32'(cs1),   32'd1);
    chk("rst_sclk1",  32'(sclk1), 32'd0);
    chk("rst_mosi1",  32'(mosi1), 32'd0);
    chk("rst_busy1",  32'(busy1), 32'd0);
    chk("rst_rdata1", rdata1,     32'd0);
    chk("rst_cs3",    32'(cs3),   32'd1);
    chk("rst_busy3",  32'(busy3), 32'd0);
    chk("rst_rdata3", rdata3,     32'd0);
    reset = 1'b0;

    // Abort at busy cycle 70 with a simultaneous strobe that reset must override.
    start_read(22'h000004);
    repeat (69) @(negedge clk);
    chk("abort_busy_before", 32'(busy1), 32'd1);
    reset = 1'b1; rstrb = 1'b1; word_addr = 22'h000005;
    @(negedge clk);
    chk("abort_cs",    32'(cs1),   32'd1);
    chk("abort_sclk",  32'(sclk1), 32'd0);
    chk("abort_busy",  32'(busy1), 32'd0);
    chk("abort_rdata", rdata1,     32'd0);
    reset = 1'b0; rstrb = 1'b0;
    @(negedge clk);
    chk("abort_no_start", 32'(busy1), 32'd0);

    for (int i = 0; i < 4; i++) begin
      sel = vec[i].sel;
      f0  = frames;
      start_read(vec[i].addr);
      wait_done(n);
      chk($sformatf("v%0d_busy", i),   n,             vec[i].busy);
      chk($sformatf("v%0d_rdata", i),  m_rdata,       vec[i].rdata);
      chk($sformatf("v%0d_cmd", i),    cmd_cap,       vec[i].cmd);
      chk($sformatf("v%0d_rises", i),  rise_cnt,      EXP_NB);
      chk($sformatf("v%0d_mosi0", i),  mosi_nz,       0);
      chk($sformatf("v%0d_frames", i), frames - f0,   1);
      chk($sformatf("v%0d_period", i), last_rise - first_rise,
          (EXP_NB - 1) * (vec[i].sel ? 6 : 2));
      chk($sformatf("v%0d_idle_cs", i), 32'(m_cs_n), 32'd1);
      @(negedge clk);
      sel = 1'b0;
    end

    // Second strobe mid-read must be dropped.
    f0 = frames;
    start_read(22'h000004);
    repeat (49) @(negedge clk);
    rstrb = 1'b1; word_addr = 22'h000100;
    @(negedge clk);
    rstrb = 1'b0;
    wait_done(n);
    chk("ign_busy",   n + 50,      BUSY1);
    chk("ign_frames", frames - f0, 1);
    chk("ign_cmd",    cmd_cap,     {EXP_OP, 24'h000010});
    chk("ign_rdata",  rdata1,      32'h44332211);

    // Back-to-back: strobe in the first idle cycle.
    start_read(22'h000000);
    wait_done(n);
    chk("b2b_busy1",  n,           BUSY1);
    chk("b2b_rdata1", rdata1,      32'hDEADBEEF);
    chk("b2b_cs_gap", 32'(cs1),    32'd1);
    rstrb = 1'b1; word_addr = 22'h000004;
    @(negedge clk);
    rstrb = 1'b0; word_addr = 22'h2AAAAA;
    chk("b2b_cs_low", 32'(cs1),    32'd0);
    chk("b2b_busy_on", 32'(busy1), 32'd1);
    repeat (5) @(negedge clk);
    chk("b2b_rdata_hold", rdata1,  32'hDEADBEEF);
    wait_done(n);
    chk("b2b_busy2",  n + 5,       BUSY1);
    chk("b2b_rdata2", rdata1,      32'h44332211);
    chk("b2b_cmd2",   cmd_cap,     {EXP_OP, 24'h000010});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
